// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the imem program loader:
//                FSM state encoding, byte width and stream header layout.
//                Optional build macro: IMEM_LOADER_CHECKSUM_EN
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

  localparam int BYTE_W     = 8;   // stream symbol width
  localparam int LEN_BYTES  = 2;   // length header: LEN_HI, LEN_LO (big-endian)
  localparam int WORD_BYTES = 2;   // each word sent as HI, LO
  localparam int LEN_W      = LEN_BYTES * BYTE_W;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHK     = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/ld_byte_pair.sv
`default_nettype none
// ============================================================================
//  Module      : ld_byte_pair
//  Description : Assembles a HI/LO byte pair into one word. The word and a
//                one-cycle word_valid appear the cycle after the LO byte is
//                taken; the word then holds until the next pair completes.
//  Revision    : 1.0  initial release
// ============================================================================
module ld_byte_pair
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [BYTE_W-1:0] hi_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;

  // Capture HI, then latch the full word and pulse valid on the LO byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= lo_en_i;
      if (hi_en_i) hi_q <= byte_i;
      if (lo_en_i) word_q <= {hi_q, byte_i};
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule : ld_byte_pair
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a length-prefixed byte-stream program image into the
//                instruction memory write port and holds the CPU core in
//                reset until the image has been fully written.
//                Optional build macro: IMEM_LOADER_CHECKSUM_EN (adds a
//                trailing 8-bit checksum byte that must match before DONE).
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import loader_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 256,
  parameter int BASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              imem_wen,
  output logic [AW-1:0]     imem_addr,
  output logic [DW-1:0]     imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  len_hi_q;
  logic [LEN_W-1:0]   len_q;
  logic [IW-1:0]      idx_q;
  logic [AW-1:0]      addr_q;
  logic [WORD_W-1:0]  word;
  logic               word_valid;
  logic               acc;
  logic               start_ok;
  logic               last_word;
  logic [LEN_W-1:0]   len_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  sum_q;
`endif

  assign acc       = in_valid & in_ready;
  assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign len_in    = {len_hi_q, in_data};
  assign last_word = (17'(idx_q) == (17'(len_q) - 17'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; every data-path transition consumes one byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI:  if (acc) state_d = S_LEN_LO;
      S_LEN_LO:  if (acc) begin
        if (len_in == '0)                       state_d = S_DONE;
        else if (32'(len_in) > 32'(DEPTH))      state_d = S_ERROR;
        else                                    state_d = S_DATA_HI;
      end
      S_DATA_HI: if (acc) state_d = S_DATA_LO;
      S_DATA_LO: if (acc) begin
        if (!last_word)  state_d = S_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else             state_d = S_CHK;
`else
        else             state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:     if (acc) state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Length capture, word index and write address bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      addr_q   <= AW'(BASE);
    end else begin
      if (start_ok) begin
        len_hi_q <= '0;
        len_q    <= '0;
        idx_q    <= '0;
      end
      if (acc && state_q == S_LEN_HI) len_hi_q <= in_data;
      if (acc && state_q == S_LEN_LO) len_q    <= len_in;
      if (acc && state_q == S_DATA_LO) begin
        // Address moves together with the word register so both change on wen.
        addr_q <= AW'(BASE) + AW'(idx_q);
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running mod-256 sum over data bytes only (length header excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (acc && (state_q == S_DATA_HI || state_q == S_DATA_LO)) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  ld_byte_pair u_pair (
    .clk          (clk),
    .rst          (rst),
    .hi_en_i      (acc && (state_q == S_DATA_HI)),
    .lo_en_i      (acc && (state_q == S_DATA_LO)),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign busy       = (state_q == S_LEN_HI) | (state_q == S_LEN_LO) |
                      (state_q == S_DATA_HI) | (state_q == S_DATA_LO) |
                      (state_q == S_CHK);
  assign in_ready   = busy;
  assign imem_wen   = word_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = DW'(word);
  // The FSM reaches DONE alongside the final write pulse; keep the core in
  // reset until that write has landed.
  assign done       = (state_q == S_DONE) & ~word_valid;
  assign cpu_rst    = ~done;
  assign error      = (state_q == S_ERROR);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected writes are
//                queued as stimulus is driven and compared on each wen.
//                Optional build macro: IMEM_LOADER_CHECKSUM_EN
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          imem_wen;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];     // {addr, data}
  logic [7:0]  stream_q[$];
  logic        prev_wen = 1'b0;

  imem_loader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .imem_wen   (imem_wen),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wen_unexpected addr=%h data=%h (no write expected)", imem_addr, imem_wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL wen_write got addr=%h data=%h expected addr=%h data=%h",
                   imem_addr, imem_wdata, e[31:16], e[15:0]);
        end
      end
      if (prev_wen) begin
        errors++;
        $display("FAIL wen_back_to_back got two consecutive pulses expected one");
      end
    end
    prev_wen <= imem_wen;
  end

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Drive stream_q; queue expected writes for each LO byte of a valid image.
  task automatic send_stream(input bit gap, input int start_at);
    int n;
    n = {stream_q[0], stream_q[1]};
    for (int i = 0; i < stream_q.size(); i++) begin
      if (gap && i > 0) @(negedge clk);
      if (n <= DEPTH && i >= 3 && i <= 1 + 2 * n && (i % 2) == 1)
        exp_q.push_back({16'(BASE + (i - 3) / 2), stream_q[i-1], stream_q[i]});
      send_byte(stream_q[i], i == start_at);
    end
  endtask

  task automatic add_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    for (int i = 2; i < stream_q.size(); i++) s = s + stream_q[i];
    stream_q.push_back(s);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d writes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, imem_wen, cpu_rst, busy, done, error} !== 6'b001000 ||
        imem_addr !== 16'(BASE) || imem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got rdy=%b wen=%b crst=%b busy=%b done=%b err=%b addr=%h data=%h expected 0 0 1 0 0 0 %h 0000",
               in_ready, imem_wen, cpu_rst, busy, done, error, imem_addr, imem_wdata, 16'(BASE));
    end
    // Bytes offered in IDLE must not be consumed.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got rdy=%b busy=%b expected 0 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL basic_start got busy=%b rdy=%b crst=%b expected 1 1 1", busy, in_ready, cpu_rst);
    end
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    add_chk();
    send_stream(1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
`endif
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL basic_wen_cycle got done=%b crst=%b expected 0 1", done, cpu_rst);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b crst=%b busy=%b expected 1 0 0", done, cpu_rst, busy);
    end
    checks++;
    if (imem_addr !== 16'(BASE + 2) || imem_wdata !== 16'h0007) begin
      errors++;
      $display("FAIL basic_hold got addr=%h data=%h expected %h 0007", imem_addr, imem_wdata, 16'(BASE + 2));
    end
    check_drained("basic");
  endtask

  task automatic test_zero_len();
    pulse_start();
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_rearm got crst=%b done=%b expected 1 0", cpu_rst, done);
    end
    stream_q = '{8'h00, 8'h00};
    send_stream(1'b0, -1);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || imem_wen !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b crst=%b wen=%b expected 1 0 0", done, cpu_rst, imem_wen);
    end
    repeat (2) @(negedge clk);
    check_drained("zero");
  endtask

  task automatic test_oversize();
    pulse_start();
    stream_q = '{8'h01, 8'h01};
    send_stream(1'b0, -1);
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL over_error got err=%b rdy=%b busy=%b crst=%b done=%b expected 1 0 0 1 0",
               error, in_ready, busy, cpu_rst, done);
    end
    in_valid = 1'b1; in_data = 8'h99;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL over_sticky got err=%b expected 1", error);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL over_rearm got err=%b busy=%b rdy=%b expected 0 1 1", error, busy, in_ready);
    end
    stream_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    add_chk();
    send_stream(1'b0, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL over_reload got done=%b expected 1", done);
    end
    check_drained("over");
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
    send_stream(1'b0, -1);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL chk_good got done=%b crst=%b expected 1 0", done, cpu_rst);
    end
    pulse_start();
    stream_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h47};
    send_stream(1'b0, -1);
    checks++;
    if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL chk_bad got err=%b crst=%b done=%b expected 1 1 0", error, cpu_rst, done);
    end
    check_drained("chk");
  endtask
`endif

  task automatic test_toggle();
    pulse_start();
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
    add_chk();
    send_stream(1'b1, 4);   // start pulsed alongside the first byte of word 1
    checks++;
    if (busy !== 1'b0 && done !== 1'b0) begin
      errors++;
      $display("FAIL toggle_state got busy=%b done=%b expected not both set", busy, done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || imem_addr !== 16'(BASE + 2)) begin
      errors++;
      $display("FAIL toggle_done got done=%b crst=%b addr=%h expected 1 0 %h",
               done, cpu_rst, imem_addr, 16'(BASE + 2));
    end
    check_drained("toggle");
  endtask

  task automatic test_rst_mid();
    pulse_start();
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    send_stream(1'b0, -1);   // now waiting on the LO byte of word 1
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hCD;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || cpu_rst !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b rdy=%b crst=%b err=%b done=%b expected 0 0 1 0 0",
               busy, in_ready, cpu_rst, error, done);
    end
    repeat (5) @(negedge clk);
    check_drained("rst_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_oversize();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_toggle();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion expected finish");
    $fatal(1);
  end

endmodule : tb_imem_loader
`default_nettype wire
